// File: rtl/barrel_shifter_if.sv
// Operand/result bundle for barrel_shifter.
//   master: drives in_valid, select, direction, shift_value, din; receives dout, out_valid
//   slave : the shifter side of the same bundle
interface barrel_shifter_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             select;
    logic             direction;
    logic [SHW-1:0]   shift_value;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             out_valid;

    modport master (
        output in_valid, select, direction, shift_value, din,
        input  dout, out_valid
    );

    modport slave (
        input  in_valid, select, direction, shift_value, din,
        output dout, out_valid
    );
endinterface

// File: rtl/barrel_shifter.sv
// Barrel shifter / rotator with a single registered output stage.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - barrel_shifter_if.slave: in_valid, select (0 shift / 1 rotate),
//           direction (0 right / 1 left), shift_value, din -> dout, out_valid
// Optional build macro: BARREL_SHIFTER_ARITH_EN makes right shifts sign-fill.
// WIDTH must be a power of two and >= 2.
module barrel_shifter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    barrel_shifter_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] operand_c;
    logic [WIDTH-1:0] right_c;
    logic [WIDTH-1:0] result_c;
    logic             fill_c;
    logic [WIDTH-1:0] dout_q;
    logic             out_valid_q;

    // Bit used for vacated MSBs of a plain right shift; left shifts arrive
    // bit-reversed and must always zero-fill.
`ifdef BARREL_SHIFTER_ARITH_EN
    assign fill_c = ~bus.select & ~bus.direction & bus.din[WIDTH-1];
`else
    assign fill_c = 1'b0;
`endif

    // Left operations are done as reverse -> right -> reverse.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign operand_c[i] = bus.direction ? bus.din[WIDTH-1-i] : bus.din[i];
        assign result_c[i]  = bus.direction ? right_c[WIDTH-1-i] : right_c[i];
    end

    // log2(WIDTH) right stages; stage k moves by 2**k when shift_value[k] is set.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = 32'd1 << k;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] cur;
        logic [AMT-1:0]   top_bits;

        if (k == 0) begin : g_first
            assign prev = operand_c;
        end else begin : g_next
            assign prev = g_stage[k-1].cur;
        end

        // Rotate wraps the low bits to the top; shift injects the fill bit.
        assign top_bits = bus.select ? prev[AMT-1:0] : {AMT{fill_c}};
        assign cur      = bus.shift_value[k] ? {top_bits, prev[WIDTH-1:AMT]} : prev;
    end

    assign right_c = g_stage[SHW-1].cur;

    // Output register: result captured on valid input, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                dout_q <= result_c;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_barrel_shifter;
    localparam int unsigned W   = 4;
    localparam int unsigned SHW = $clog2(W);
    localparam int unsigned MASK = (32'd1 << W) - 32'd1;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic [W-1:0] hold_val;

    barrel_shifter_if #(.WIDTH(W)) bus ();

    barrel_shifter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer shifts on the word value.
    function automatic logic [W-1:0] ref_f(input logic sel, input logic dir,
                                           input int unsigned n, input logic [W-1:0] d);
        int unsigned v;
        int unsigned r;
        v = 32'(d);
        if (sel) begin
            if (dir) r = (v << n) | (v >> (W - n));
            else     r = (v >> n) | (v << (W - n));
        end else if (dir) begin
            r = v << n;
        end else begin
            r = v >> n;
`ifdef BARREL_SHIFTER_ARITH_EN
            if (d[W-1]) r = r | (MASK & ~(MASK >> n));
`endif
        end
        return W'(r & MASK);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic dir,
                         input logic [SHW-1:0] n, input logic [W-1:0] d);
        bus.in_valid    = v;
        bus.select      = sel;
        bus.direction   = dir;
        bus.shift_value = n;
        bus.din         = d;
    endtask

    // One clock: update the model from the sampled inputs, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            exp_valid = bus.in_valid;
            if (bus.in_valid)
                exp_dout = ref_f(bus.select, bus.direction, 32'(bus.shift_value), bus.din);
        end
        #1;
        check({tag, ".dout"}, bus.dout, exp_dout);
        check({tag, ".out_valid"}, W'(bus.out_valid), W'(exp_valid));
    endtask

    // Directed operation with a literal expected result as well as the model.
    task automatic op_chk(input string tag, input logic sel, input logic dir,
                          input logic [SHW-1:0] n, input logic [W-1:0] d,
                          input logic [W-1:0] want);
        drive(1'b1, sel, dir, n, d);
        tick(tag);
        check({tag, ".literal"}, bus.dout, want);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        rst_n       = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("reset.dout", bus.dout, '0);
        check("reset.out_valid", W'(bus.out_valid), '0);
        tick("reset_hold");
        tick("reset_hold");
        rst_n = 1'b1;

        // Logical right, back to back
        op_chk("lsr1", 1'b0, 1'b0, 2'd1, 4'b0100, 4'b0010);
        op_chk("lsr2", 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0001);
        op_chk("lsr3", 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0000);

        // Right shift of MSB-set word
`ifdef BARREL_SHIFTER_ARITH_EN
        op_chk("asr1", 1'b0, 1'b0, 2'd1, 4'b1000, 4'b1100);
        op_chk("asr2", 1'b0, 1'b0, 2'd2, 4'b1000, 4'b1110);
        op_chk("asr3", 1'b0, 1'b0, 2'd3, 4'b1000, 4'b1111);
`else
        op_chk("msr1", 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0100);
        op_chk("msr2", 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0010);
        op_chk("msr3", 1'b0, 1'b0, 2'd3, 4'b1000, 4'b0001);
`endif

        // Rotate right
        op_chk("ror1", 1'b1, 1'b0, 2'd1, 4'b1011, 4'b1101);
        op_chk("ror2", 1'b1, 1'b0, 2'd2, 4'b1011, 4'b1110);
        op_chk("ror3", 1'b1, 1'b0, 2'd3, 4'b1011, 4'b0111);
        op_chk("ror0", 1'b1, 1'b0, 2'd0, 4'b1011, 4'b1011);

        // Left operations
        op_chk("lsl1", 1'b0, 1'b1, 2'd1, 4'b0001, 4'b0010);
        op_chk("lsl2", 1'b0, 1'b1, 2'd2, 4'b0001, 4'b0100);
        op_chk("lsl3", 1'b0, 1'b1, 2'd3, 4'b0001, 4'b1000);
        op_chk("rol1", 1'b1, 1'b1, 2'd1, 4'b1011, 4'b0111);
        op_chk("rol2", 1'b1, 1'b1, 2'd2, 4'b1011, 4'b1110);
        op_chk("rol3", 1'b1, 1'b1, 2'd3, 4'b1011, 4'b1101);
        op_chk("lsl0", 1'b0, 1'b1, 2'd0, 4'b0110, 4'b0110);
        op_chk("rol_ones", 1'b1, 1'b1, 2'd3, 4'b1111, 4'b1111);
        op_chk("ror_zero", 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000);

        // in_valid gap: result must hold while din changes
        op_chk("gap_op", 1'b1, 1'b1, 2'd1, 4'b1001, 4'b0011);
        hold_val = exp_dout;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd2, W'($urandom));
            tick("gap");
            check("gap.hold", bus.dout, hold_val);
        end

        // Random operations with random valid gaps
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  SHW'($urandom), W'($urandom));
            tick("rand");
        end

        // Reset asserted mid-cycle with a result present
        op_chk("pre_rst", 1'b1, 1'b0, 2'd1, 4'b0110, 4'b0011);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 4'b0101);
        #3;
        rst_n     = 1'b0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        #1;
        check("midrst.dout", bus.dout, '0);
        check("midrst.out_valid", W'(bus.out_valid), '0);
        tick("midrst_hold");
        #3;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 2'd1, 4'b0111);
        tick("post_rst_idle");
        op_chk("post_rst_op", 1'b0, 1'b1, 2'd1, 4'b0001, 4'b0010);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick("tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Parameterised combinational barrel shifter/rotator with a registered output stage: shifts or rotates a WIDTH-bit word left or right by 0..WIDTH-1 positions.
- Sits in datapath ALU/operand paths; one-cycle latency from input capture to dout.
- Default configuration is a 4-bit datapath.

Parameters:
- WIDTH, 4, data width in bits; must be a power of two and >= 2.
- SHW, $clog2(WIDTH), width of shift_value; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
- in_valid  input  1  input qualifier; operands are sampled on a clk edge with in_valid=1.
- select  input  1  0 = shift, 1 = rotate.
- direction  input  1  0 = right, 1 = left.
- shift_value  input  SHW  shift/rotate amount, 0..WIDTH-1.
- din  input  WIDTH  operand.
- dout  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle when dout holds a new result.

Behaviour:
- Reset (rst_n=0, asynchronous): dout=0, out_valid=0 immediately; held while rst_n=0.
- Reset mid-operation: any pending result is discarded; out_valid=0 on the first edge after release unless in_valid=1 on that edge.
- On each rising clk edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1: dout <= f(select, direction, shift_value, din).
  - If in_valid=0: dout holds its previous value.
- Latency: exactly 1 cycle. A full throughput of one operation per cycle is supported, with no stall and no back-pressure.
- Function f, with n = shift_value:
  - select=0, direction=0: logical right shift. Vacated MSBs are filled with 0 (see the optional feature for sign fill).
  - select=0, direction=1: logical left shift. Vacated LSBs are filled with 0.
  - select=1, direction=0: rotate right. Bit i of the result = din[(i+n) mod WIDTH].
  - select=1, direction=1: rotate left. Bit i of the result = din[(i-n) mod WIDTH].
- Boundary conditions:
  - n=0: result = din for all four modes.
  - n=WIDTH-1: maximum shift. A logical shift leaves at most one surviving bit.
- Implementation: log2(WIDTH) mux stages (shift by 1, 2, 4, ...), each stage enabled by one bit of shift_value. A left operation may be implemented as bit-reverse, right operation, bit-reverse.
- Rotating an all-zero or all-one word returns the same value.

Optional Feature:
- Macro: BARREL_SHIFTER_ARITH_EN.
- Defined: for select=0, direction=0, vacated MSBs are filled with din[WIDTH-1] (arithmetic right shift). Left shifts and rotates are unchanged.
- Undefined: right shift always zero-fills (logical).

Test Plan:
- Reset and hold: assert rst_n=0 mid-stream with in_valid=1 -> dout=0000 and out_valid=0 immediately. After release with in_valid=0 -> outputs remain 0. With in_valid=1, din=0001, select=0, direction=1, n=1 -> dout=0010 and out_valid=1 one cycle later.
- Logical right, din=0100: n=1 -> 0010; n=2 -> 0001; n=3 -> 0000. Driven back-to-back on consecutive cycles, each result appears exactly one cycle after its operands.
- Right shift, din=1000, n=1/2/3:
  - Without BARREL_SHIFTER_ARITH_EN -> 0100 / 0010 / 0001.
  - With BARREL_SHIFTER_ARITH_EN -> 1100 / 1110 / 1111.
- Rotate right, din=1011: n=1 -> 1101; n=2 -> 1110; n=3 -> 0111. n=0 -> 1011.
- Left operations:
  - Shift left, din=0001: n=1/2/3 -> 0010 / 0100 / 1000.
  - Rotate left, din=1011: n=1/2/3 -> 0111 / 1110 / 1101.
- in_valid gap: issue an operation, then hold in_valid=0 for 3 cycles while changing din -> dout is unchanged and out_valid=0 during the gap.
